div_radix4_param: RTL and testbench

- Parametrised multi-cycle radix-4 integer divider for the EX stage (DIV/DIVU).
- Retires 2 quotient bits per cycle.
- Adds to the existing divider: width generalisation, a cancel input, a divide-by-zero flag, operand latching, and a dedicated sign-fixup state with remainder sign taken from the dividend.
- Returns {remainder, quotient} and holds it until EX drops start.

---
 rtl/div_radix4_param.sv | 216 +++++++++++++++++++++
 tb/tb_div_radix4_param.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_radix4_param.sv
// Radix-4 multi-cycle integer divider for the EX stage (DIV/DIVU).
// Retires two quotient bits per cycle and returns {remainder, quotient}.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start_i       level request (1 = start/hold, 0 = release)
//   signed_div_i  1 = signed DIV, 0 = DIVU; sampled with start
//   annul_i       flush; aborts any in-flight operation
//   opdata1_i     dividend
//   opdata2_i     divisor
//   result_o      {remainder, quotient}, valid while ready_o
//   ready_o       result valid
//   busy_o        operation in flight
//   div_zero_o    divisor was zero; valid while ready_o
//
// Optional macro DIV_EARLY_SKIP_EN: skip leading zero bit pairs of the
// dividend so small dividends finish in fewer iterations.
module div_radix4_param #(
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                signed_div_i,
    input  logic                annul_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o,
    output logic                busy_o,
    output logic                div_zero_o
);

    localparam int HW = DATA_W / 2;
    localparam int CW = $clog2(HW + 1);
    localparam int PW = DATA_W + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_ZERO, S_ON, S_FIX, S_END
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]     cnt_q;
    logic [PW-1:0]     pr_q;
    logic [DATA_W-1:0] dvd_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] dsr_q;
    logic              sgn_q, s1_q, s2_q, dz_q;

    logic [DATA_W-1:0] abs1, abs2, dvd_init;
    logic [CW-1:0]     iter_init;
    logic [PW-1:0]     t, d1, d2, d3, pr_next;
    logic [PW:0]       r1, r2, r3;
    logic [1:0]        digit;

    // Operand magnitudes; negating MIN yields 2^(DATA_W-1) unsigned.
    always_comb begin
        abs1 = opdata1_i;
        abs2 = opdata2_i;
        if (signed_div_i && opdata1_i[DATA_W-1])
            abs1 = -opdata1_i;
        if (signed_div_i && opdata2_i[DATA_W-1])
            abs2 = -opdata2_i;
    end

`ifdef DIV_EARLY_SKIP_EN
    logic [CW-1:0] lzp;
    logic          found;

    always_comb begin
        lzp   = CW'(HW);
        found = 1'b0;
        for (int i = HW - 1; i >= 0; i--) begin
            if (!found && abs1[2*i +: 2] != 2'b00) begin
                lzp   = CW'(HW - 1 - i);
                found = 1'b1;
            end
        end
        dvd_init = abs1 << {lzp, 1'b0};
        if (lzp == CW'(HW))
            iter_init = CW'(1);
        else
            iter_init = CW'(HW) - lzp;
    end
`else
    always_comb begin
        dvd_init  = abs1;
        iter_init = CW'(HW);
    end
`endif

    // One radix-4 step. PR < d always holds, so T fits in PW bits.
    always_comb begin
        t  = {pr_q[PW-3:0], dvd_q[DATA_W-1 -: 2]};
        d1 = {2'b00, dsr_q};
        d2 = d1 << 1;
        d3 = d1 + d2;
        r3 = {1'b0, t} - {1'b0, d3};
        r2 = {1'b0, t} - {1'b0, d2};
        r1 = {1'b0, t} - {1'b0, d1};
        digit   = 2'd0;
        pr_next = t;
        unique case (1'b1)
            !r3[PW]: begin
                digit   = 2'd3;
                pr_next = r3[PW-1:0];
            end
            r3[PW] && !r2[PW]: begin
                digit   = 2'd2;
                pr_next = r2[PW-1:0];
            end
            r2[PW] && !r1[PW]: begin
                digit   = 2'd1;
                pr_next = r1[PW-1:0];
            end
            r1[PW]: begin
                digit   = 2'd0;
                pr_next = t;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:
                if (start_i)
                    state_d = (opdata2_i == '0) ? S_ZERO : S_ON;
            S_ZERO:
                state_d = S_END;
            S_ON:
                if (cnt_q == CW'(1))
                    state_d = S_FIX;
            S_FIX:
                state_d = S_END;
            S_END:
                if (!start_i)
                    state_d = S_IDLE;
            default:
                state_d = S_IDLE;
        endcase
        if (annul_i)
            state_d = S_IDLE;
    end

    always_comb begin
        ready_o    = (state_q == S_END);
        busy_o     = (state_q == S_ZERO) || (state_q == S_ON) ||
                     (state_q == S_FIX);
        div_zero_o = ready_o && dz_q;
        result_o   = ready_o ? {pr_q[DATA_W-1:0], quo_q} : '0;
    end

    always_ff @(posedge clk) begin
        if (rst || annul_i) begin
            cnt_q <= '0;
            pr_q  <= '0;
            dvd_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            sgn_q <= 1'b0;
            s1_q  <= 1'b0;
            s2_q  <= 1'b0;
            dz_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE:
                    if (start_i) begin
                        if (opdata2_i == '0) begin
                            pr_q  <= {2'b00, opdata1_i};
                            quo_q <= '1;
                            dz_q  <= 1'b1;
                        end else begin
                            sgn_q <= signed_div_i;
                            s1_q  <= opdata1_i[DATA_W-1];
                            s2_q  <= opdata2_i[DATA_W-1];
                            dsr_q <= abs2;
                            dvd_q <= dvd_init;
                            cnt_q <= iter_init;
                            pr_q  <= '0;
                            quo_q <= '0;
                            dz_q  <= 1'b0;
                        end
                    end
                S_ON: begin
                    pr_q  <= pr_next;
                    quo_q <= {quo_q[DATA_W-3:0], digit};
                    dvd_q <= dvd_q << 2;
                    cnt_q <= cnt_q - CW'(1);
                end
                S_FIX: begin
                    if (sgn_q && (s1_q ^ s2_q))
                        quo_q <= -quo_q;
                    if (sgn_q && s1_q)
                        pr_q <= -pr_q;
                end
                S_END:
                    if (!start_i) begin
                        pr_q  <= '0;
                        quo_q <= '0;
                        dz_q  <= 1'b0;
                    end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_radix4_param.sv
// Directed testbench for div_radix4_param (DATA_W = 32).
// Runs unsigned, signed, divide-by-zero, annul and reset scenarios.
module tb_div_radix4_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        signed_div_i;
    logic        annul_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;
    logic        div_zero_o;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    div_radix4_param #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .signed_div_i (signed_div_i),
        .annul_i      (annul_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o),
        .div_zero_o   (div_zero_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected latency for a nonzero divisor, from the dividend magnitude.
    function automatic int exp_lat(input logic [31:0] mag);
        int p;
        int it;
        logic [1:0] pr;
        p  = 16;
        it = 16;
`ifdef DIV_EARLY_SKIP_EN
        for (int i = 15; i >= 0; i--) begin
            pr = mag[2*i +: 2];
            if (p == 16 && pr != 2'b00)
                p = 15 - i;
        end
        it = (16 - p < 1) ? 1 : 16 - p;
`else
        p  = (mag == 32'd0) ? 16 : 0;
        it = 16 + 0 * p;
`endif
        return it + 2;
    endfunction

    // Drives start and waits for ready; scrambles operands after the
    // sampling edge. Returns -1 on timeout. Leaves start_i high.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic sgn, output int lat);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = sgn;
        start_i      = 1'b1;
        lat          = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tick();
            if (cyc == 1) begin
                opdata1_i    = 32'hDEAD_BEEF;
                opdata2_i    = 32'h0;
                signed_div_i = ~sgn;
            end
            if (ready_o) begin
                lat = cyc;
                break;
            end
        end
    endtask

    task automatic release_start();
        start_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        start_i = 1'b0;
        annul_i = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        vectors += 4;
        if (result_o !== 64'h0) begin
            errors++;
            $display("FAIL reset_result got %h want 0", result_o);
        end
        if (ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got %b want 0", ready_o);
        end
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", busy_o);
        end
        if (div_zero_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_dz got %b want 0", div_zero_o);
        end
    endtask

    task automatic test_unsigned();
        int lat;
        do_op(32'd100, 32'd7, 1'b0, lat);
        vectors += 3;
        if (lat != exp_lat(32'd100)) begin
            errors++;
            $display("FAIL u100_7_lat got %0d want %0d",
                     lat, exp_lat(32'd100));
        end
        if (result_o !== {32'h2, 32'hE}) begin
            errors++;
            $display("FAIL u100_7_res got %h want %h",
                     result_o, {32'h2, 32'hE});
        end
        if (div_zero_o !== 1'b0) begin
            errors++;
            $display("FAIL u100_7_dz got %b want 0", div_zero_o);
        end
        tick();
        tick();
        tick();
        vectors += 2;
        if (ready_o !== 1'b1 || result_o !== {32'h2, 32'hE}) begin
            errors++;
            $display("FAIL u100_7_hold got rdy=%b %h want rdy=1 %h",
                     ready_o, result_o, {32'h2, 32'hE});
        end
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL u100_7_busy got %b want 0", busy_o);
        end
        release_start();
        vectors += 2;
        if (ready_o !== 1'b0) begin
            errors++;
            $display("FAIL u100_7_drop_rdy got %b want 0", ready_o);
        end
        if (result_o !== 64'h0) begin
            errors++;
            $display("FAIL u100_7_drop_res got %h want 0", result_o);
        end
    endtask

    task automatic test_signed();
        logic [31:0] a [3];
        logic [31:0] b [3];
        logic [31:0] m [3];
        logic [63:0] e [3];
        int lat;
        a[0] = 32'hFFFF_FFF9; b[0] = 32'h2;
        m[0] = 32'd7;
        e[0] = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
        a[1] = 32'h7;         b[1] = 32'hFFFF_FFFE;
        m[1] = 32'd7;
        e[1] = {32'h0000_0001, 32'hFFFF_FFFD};
        a[2] = 32'h8000_0000; b[2] = 32'hFFFF_FFFF;
        m[2] = 32'h8000_0000;
        e[2] = {32'h0, 32'h8000_0000};
        for (int i = 0; i < 3; i++) begin
            do_op(a[i], b[i], 1'b1, lat);
            vectors += 3;
            if (lat != exp_lat(m[i])) begin
                errors++;
                $display("FAIL signed%0d_lat got %0d want %0d",
                         i, lat, exp_lat(m[i]));
            end
            if (result_o !== e[i]) begin
                errors++;
                $display("FAIL signed%0d_res got %h want %h",
                         i, result_o, e[i]);
            end
            if (div_zero_o !== 1'b0) begin
                errors++;
                $display("FAIL signed%0d_dz got %b want 0",
                         i, div_zero_o);
            end
            release_start();
        end
    endtask

    task automatic test_div_zero();
        int lat;
        do_op(32'h1234_5678, 32'h0, 1'b0, lat);
        vectors += 3;
        if (lat != 2) begin
            errors++;
            $display("FAIL dz_lat got %0d want 2", lat);
        end
        if (div_zero_o !== 1'b1) begin
            errors++;
            $display("FAIL dz_flag got %b want 1", div_zero_o);
        end
        if (result_o !== {32'h1234_5678, 32'hFFFF_FFFF}) begin
            errors++;
            $display("FAIL dz_res got %h want %h",
                     result_o, {32'h1234_5678, 32'hFFFF_FFFF});
        end
        release_start();
        vectors++;
        if (div_zero_o !== 1'b0) begin
            errors++;
            $display("FAIL dz_drop got %b want 0", div_zero_o);
        end
    endtask

    task automatic test_annul();
        int seen;
        int lat;
        opdata1_i    = 32'hFFFF_FFFF;
        opdata2_i    = 32'h3;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        for (int c = 1; c <= 4; c++)
            tick();
        annul_i = 1'b1;
        start_i = 1'b0;
        tick();
        annul_i = 1'b0;
        vectors += 2;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL annul_busy got %b want 0", busy_o);
        end
        if (result_o !== 64'h0) begin
            errors++;
            $display("FAIL annul_res got %h want 0", result_o);
        end
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (ready_o !== 1'b0)
                seen++;
        end
        vectors++;
        if (seen != 0) begin
            errors++;
            $display("FAIL annul_ready got %0d ready cycles want 0",
                     seen);
        end
        do_op(32'd10, 32'd3, 1'b0, lat);
        vectors += 2;
        if (lat != exp_lat(32'd10)) begin
            errors++;
            $display("FAIL after_annul_lat got %0d want %0d",
                     lat, exp_lat(32'd10));
        end
        if (result_o !== {32'h1, 32'h3}) begin
            errors++;
            $display("FAIL after_annul_res got %h want %h",
                     result_o, {32'h1, 32'h3});
        end
        release_start();
    endtask

    task automatic test_small();
        int lat;
        do_op(32'd5, 32'd1, 1'b0, lat);
        vectors += 2;
        if (lat != exp_lat(32'd5)) begin
            errors++;
            $display("FAIL u5_1_lat got %0d want %0d",
                     lat, exp_lat(32'd5));
        end
        if (result_o !== {32'h0, 32'h5}) begin
            errors++;
            $display("FAIL u5_1_res got %h want %h",
                     result_o, {32'h0, 32'h5});
        end
        release_start();
    endtask

    task automatic test_reset_mid();
        opdata1_i    = 32'h0012_3456;
        opdata2_i    = 32'h11;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        tick();
        tick();
        tick();
        rst     = 1'b1;
        start_i = 1'b0;
        tick();
        rst = 1'b0;
        vectors += 3;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_busy got %b want 0", busy_o);
        end
        if (ready_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ready got %b want 0", ready_o);
        end
        if (result_o !== 64'h0) begin
            errors++;
            $display("FAIL rstmid_res got %h want 0", result_o);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_annul();
        test_small();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
